// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the async FIFO: prefetches words into a small buffer and
// presents them on valid/ready. Optional statistics ports are enabled by FIFO_RD_STATS_EN.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                         r_clk,
  input  logic                         rst_r,
  input  logic                         fifo_empty,
  input  logic [WIDTH-1:0]             fifo_rdata,
  output logic                         fifo_ren,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  input  logic                         flush,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]                  stat_words,
  output logic [31:0]                  stat_drop
`endif
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_pend;
  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic             w_ren;
  logic             w_pop;
  logic             w_cap;
  logic             w_clear;
  logic [CW-1:0]    w_credit;
  logic [PW-1:0]    w_head_nxt, w_tail_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;

  assign w_credit = r_count + CW'(r_pend);
  assign w_clear  = flush;
  assign w_pop    = r_valid && m_ready;
  // Words arriving while flushing (or on the flush cycle itself) are discarded.
  assign w_cap    = r_pend && (r_state == StRun) && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    unique case (r_state)
      StRun: begin
        if (flush) begin
          w_state_nxt = StFlush;
          w_ren       = !fifo_empty;
        end else begin
          w_ren = !fifo_empty && (w_credit < CW'(BUF_DEPTH));
        end
      end
      StFlush: begin
        if (flush) begin
          w_ren = !fifo_empty;
        end else if (!r_pend) begin
          w_state_nxt = StRun;
        end
      end
      default: w_state_nxt = StRun;
    endcase
  end

  assign fifo_ren = w_ren && !rst_r;

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (w_clear) begin
      w_head_nxt  = r_tail;
      w_count_nxt = '0;
    end else begin
      if (w_pop) w_head_nxt = r_head + PW'(1);
      if (w_cap) w_tail_nxt = r_tail + PW'(1);
      case ({w_cap, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // The next head word may be the one being captured right now, so bypass the array.
  assign w_data_nxt = (w_cap && (r_tail == w_head_nxt)) ? fifo_rdata : r_mem[w_head_nxt];

  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r) begin
      r_state <= StRun;
      r_pend  <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= fifo_ren;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_data  <= w_data_nxt;
    end
  end

  always_ff @(posedge r_clk) begin
    if (w_cap) r_mem[r_tail] <= fifo_rdata;
  end

  assign m_valid   = r_valid;
  assign m_data    = r_data;
  assign buf_count = r_count;

`ifdef FIFO_RD_STATS_EN
  logic [31:0]   r_stat_words, r_stat_drop;
  logic [CW-1:0] w_drop_n;
  logic [32:0]   w_drop_sum;

  // Cleared entries plus any in-flight word that is not captured.
  assign w_drop_n   = (w_clear ? (r_count - CW'(w_pop)) : '0) + CW'(r_pend && !w_cap);
  assign w_drop_sum = {1'b0, r_stat_drop} + 33'(w_drop_n);

  always_ff @(posedge r_clk or posedge rst_r) begin
    if (rst_r) begin
      r_stat_words <= '0;
      r_stat_drop  <= '0;
    end else begin
      if (w_pop && (r_stat_words != '1)) r_stat_words <= r_stat_words + 32'd1;
      r_stat_drop <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end
  end

  assign stat_words = r_stat_words;
  assign stat_drop  = r_stat_drop;
`endif

endmodule
